// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants, FSM state encoding and funct3 decode helpers
//            for the RV64M multiply execution unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // RV64M multiply funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Instruction fields used by the control unit to recognise MUL*/DIV*
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // High half of the product is returned for MULH, MULHSU and MULHU;
  // every other code (including reserved ones) behaves as MUL.
  function automatic logic f3_is_high(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

  // op_a is treated as signed for MULH and MULHSU
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU);
  endfunction

  // op_b is treated as signed only for MULH
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mul_ex_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_ex_unit_if
// Brief    : Request/response bundle between the EX stage datapath and the
//            multi-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_ex_unit_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic              flush;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        rd_in;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [4:0]        rd_out;

  // Pipeline side: issues the multiply and consumes the result
  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  stall, busy, done, result, rd_out
  );

  // Multiplier side
  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output stall, busy, done, result, rd_out
  );
endinterface : mul_ex_unit_if
`default_nettype wire

// File: rtl/mul_ex_unit_core.sv
`default_nettype none
// ============================================================================
// Module   : mul_core
// Brief    : Registered 2*DATA_W multiplier with per-operand sign extension.
//            The full product is formed in the first register stage and then
//            retimed through STAGES-1 further registers.
// Revision : 1.0 - initial release
// ============================================================================
module mul_core #(
  parameter int DATA_W = 64,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                a_signed,
  input  logic                b_signed,
  output logic [2*DATA_W-1:0] product
);

  // Two guard bits above 2*DATA_W keep the signed multiply exact for every
  // signed/unsigned combination.
  localparam int c_ext_w = 2*DATA_W + 2;

  logic signed [c_ext_w-1:0]  w_a_ext;
  logic signed [c_ext_w-1:0]  w_b_ext;
  logic        [2*DATA_W-1:0] w_full;
  logic        [2*DATA_W-1:0] r_pipe [STAGES];

  assign w_a_ext = {{(DATA_W+2){a_signed & a[DATA_W-1]}}, a};
  assign w_b_ext = {{(DATA_W+2){b_signed & b[DATA_W-1]}}, b};
  assign w_full  = (2*DATA_W)'(w_a_ext * w_b_ext);

  // Product register chain; depth sets the multiplier latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_full;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign product = r_pipe[STAGES-1];

endmodule : mul_core
`default_nettype wire

// File: rtl/mul_ex_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_ex_unit
// Brief    : EX-stage RV64M multiplier sequencer. Latches the operands on
//            acceptance, stalls the front of the pipeline for LATENCY cycles
//            and presents a one-cycle done pulse with the selected product.
//            LATENCY must lie in 2..8.
// Revision : 1.0 - initial release
// ============================================================================
module mul_ex_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst,
  mul_ex_unit_if.slave bus
);

  localparam int              CNT_W      = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LATENCY - 1);

  mul_state_t          r_state;
  mul_state_t          w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2:0]          r_f3;
  logic [4:0]          r_rd;
  logic                w_accept;
  logic                w_stall;
  logic                w_done;
  logic                w_high;
  logic [2*DATA_W-1:0] w_prod;

  assign w_accept = (r_state == IDLE) & bus.start & ~bus.flush;

  // State, counter and operand/rd latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= bus.op_a;
        r_b   <= bus.op_b;
        r_f3  <= bus.funct3;
        r_rd  <= bus.rd_in;
        r_cnt <= CNT_W'(1);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next state plus stall/done; a flush overrides everything and squashes
  // both outputs in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next  = BUSY;
          w_stall = 1'b1;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == c_cnt_last) w_next = DONE;
      end
      DONE: begin
        // The same MUL still sits in EX here, so start is ignored
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (bus.flush) begin
      w_next  = IDLE;
      w_stall = 1'b0;
      w_done  = 1'b0;
    end
  end

  mul_core #(
    .DATA_W (DATA_W),
    .STAGES (LATENCY - 1)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .a        (r_a),
    .b        (r_b),
    .a_signed (f3_a_signed(r_f3)),
    .b_signed (f3_b_signed(r_f3)),
    .product  (w_prod)
  );

  assign w_high     = f3_is_high(r_f3);
  assign bus.stall  = w_stall;
  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = w_done;
  assign bus.result = w_done ? (w_high ? w_prod[2*DATA_W-1:DATA_W] : w_prod[DATA_W-1:0]) : '0;
  assign bus.rd_out = w_done ? r_rd : 5'd0;

endmodule : mul_ex_unit
`default_nettype wire

// File: doc/mul_ex_unit.md
Name: mul_ex_unit

Overview:
- Multi-cycle 64-bit integer multiplier for the EX stage of the 5-stage RISC-V pipeline (RV64M MUL/MULH/MULHSU/MULHU).
- Consumes the forwarded EX operands and the multiply request decoded into ID/EX.
- Produces the product for the EX/MEM register.
- Raises a stall that freezes the PC and the IF/ID and ID/EX registers, and holds EX/MEM input as a bubble, until the result is ready.

Parameters:
- DATA_W, 64, operand and result width.
- LATENCY, 3, cycles from the accepted request to `done`; legal range 2..8.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  a valid multiply instruction is present in EX this cycle.
- flush  in  1  EX instruction is squashed (branch/jump taken in MEM); aborts the operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes behave as MUL.
- op_a  in  DATA_W  forwarded rs1 value (output of forwarding mux A).
- op_b  in  DATA_W  forwarded rs2 value (output of forwarding mux B).
- rd_in  in  5  destination register of the EX instruction.
- stall  out  1  freeze request for upstream pipeline registers and PC.
- busy  out  1  operation in flight (state != IDLE).
- done  out  1  result valid this cycle; single-cycle pulse.
- result  out  DATA_W  product selected by funct3; valid while `done` = 1.
- rd_out  out  5  latched rd, valid with `done`.

Behaviour:
- Reset: synchronous, active-high. `rst` = 1 at a clock edge forces state IDLE, cnt = 0, all latched operands = 0, and stall, busy, done, result, rd_out = 0. This applies mid-operation; no `done` follows an aborted operation.
- States: IDLE, BUSY, DONE. Counter cnt is $clog2(LATENCY)+1 bits wide.
- IDLE:
  - stall = start & ~flush, combinational, so the stall is asserted in the same cycle the MUL sits in EX.
  - On start & ~flush: latch op_a, op_b, funct3, rd_in; cnt <= 1; go to BUSY.
- BUSY:
  - stall = 1, busy = 1.
  - cnt increments each cycle; when cnt == LATENCY-1, go to DONE.
  - `start` is ignored.
- DONE:
  - stall = 0, done = 1, result and rd_out driven from latched/registered data.
  - Next state IDLE unconditionally.
  - `start` is ignored, because the same MUL is still in EX this cycle and must not retrigger.
  - A back-to-back MUL is accepted in the following IDLE cycle.
- Timing:
  - Request accepted at cycle 0; done at cycle LATENCY.
  - stall is high for exactly LATENCY cycles (0..LATENCY-1).
  - For LATENCY = 3, EX occupancy is 4 cycles.
- flush:
  - In any state, flush = 1 forces the next state to IDLE.
  - Outputs in the flush cycle: stall = 0 and done = 0.
  - rst takes priority over flush.
- Arithmetic: full 2*DATA_W product; operands are sign- or zero-extended to 2*DATA_W+2 per funct3.
  - MUL: product[63:0], sign-agnostic.
  - MULH: signed × signed, product[127:64].
  - MULHSU: signed op_a × unsigned op_b, product[127:64].
  - MULHU: unsigned × unsigned, product[127:64].
  - No overflow flag.
- Internal pipelining of partial products is free, provided the latency is exactly LATENCY and the result is registered.
- result holds 0 when done = 0.
- Operands are latched at acceptance; later changes to op_a/op_b (forwarding updates) have no effect.

Decomposition:
- Shared package (cpu_pkg):
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - State encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2).
  - OPCODE_OP (7'b0110011) and FUNCT7_MULDIV (7'b0000001) for the control unit.
- Sub-module mul_core:
  - Registered 2*DATA_W signed/unsigned multiplier with sign-extension controls.
  - Contains the pipeline of partial products.
  - mul_ex_unit holds only the FSM, the counter, and the operand/rd latches.

Test Plan:
- Reset mid-op: start MUL 5×7, assert rst at cycle 1 -> cycle 2: stall=0, busy=0, done=0, result=0; no done pulse follows.
- Basic MUL: op_a=5, op_b=7, funct3=000, rd_in=9, start 1 cycle (held while stall) -> stall high in cycles 0-2; cycle 3: done=1, result=35, rd_out=9; cycle 4: done=0.
- Signed high parts with op_a=-1 (0xFFFF_FFFF_FFFF_FFFF) and op_b=2:
  - MULH -> 0xFFFF_FFFF_FFFF_FFFF.
  - MULHU -> 1.
  - MULHSU -> 0xFFFF_FFFF_FFFF_FFFF.
  - MUL -> 0xFFFF_FFFF_FFFF_FFFE.
- Back-to-back: two MULs (3×4, then 0x1_0000_0000 × 0x1_0000_0000 with MULHU) -> first done at cycle 3 with 12, no retrigger in DONE; second accepted at cycle 4, done at cycle 7 with result=1.
- Flush: start at cycle 0, flush=1 at cycle 1 -> stall=0 in cycle 1, state IDLE at cycle 2, no done; new start at cycle 2 is accepted normally.
- Operand isolation: change op_a from 6 to 100 during BUSY with op_b=6 -> done result=36.
